// File: rtl/wb_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_reader
// Purpose  : Wishbone master that reads a contiguous HyperRAM region with
//            incrementing bursts and streams the words out on a valid/ready
//            source. A burst is launched only once the internal FIFO can hold
//            every beat of it, so wishbone_ack never has to be stalled.
// Ports    : clock/reset         - clock, synchronous active-high reset
//            start/base_adr/length - transfer request (sampled on acceptance)
//            busy/done/error     - transfer status (error is sticky)
//            wishbone_*          - wishbone master (read-only, linear bursts)
//            source_*            - 32-bit word stream with end-of-transfer tag
// Revision : 1.0 - initial release
// ============================================================================
module wb_burst_reader #(
    parameter int BURST_LEN  = 16,  // max beats per burst, >= 1
    parameter int FIFO_DEPTH = 32   // power of two, >= BURST_LEN and >= 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [29:0] base_adr,
    input  logic [23:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [29:0] wishbone_adr,
    input  logic [31:0] wishbone_dat_r,
    output logic [31:0] wishbone_dat_w,
    output logic [3:0]  wishbone_sel,
    output logic        wishbone_cyc,
    output logic        wishbone_stb,
    output logic        wishbone_we,
    output logic [2:0]  wishbone_cti,
    output logic [1:0]  wishbone_bte,
    input  logic        wishbone_ack,
    input  logic        wishbone_err,
    output logic        source_valid,
    input  logic        source_ready,
    output logic [31:0] source_data,
    output logic        source_last
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;                 // pointer carries a wrap bit
    localparam int BCW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_BURST      = 2'd2,
        ST_DRAIN      = 2'd3
    } state_t;

    state_t          state_q;
    logic [29:0]     adr_q;
    logic [23:0]     remaining_q;
    logic [BCW-1:0]  beat_cnt_q;
    logic [2:0]      cti_q;
    logic            cyc_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;

    // FIFO storage: bit 32 is the end-of-transfer tag.
    logic [32:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [PW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            abort;
    logic [PW:0]     fifo_free;
    logic [BCW-1:0]  beats;
    logic            space_ok;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && source_ready;
    assign push       = (state_q == ST_BURST) && wishbone_ack && !wishbone_err;
    assign abort      = (state_q == ST_BURST) && wishbone_err;

    // A word leaving this cycle already frees its slot for the next burst.
    assign fifo_free  = (PW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} + {{PW{1'b0}}, pop};
    assign beats      = (remaining_q < 24'(BURST_LEN)) ? remaining_q[BCW-1:0]
                                                       : BCW'(BURST_LEN);
    assign space_ok   = fifo_free >= (PW+1)'(beats);

    // An error flushes everything buffered; the erroring beat is never pushed.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d = abort ? wr_ptr_q : rd_ptr_q + {{(PW-1){1'b0}}, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {(remaining_q == 24'd1), wishbone_dat_r};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            cti_q       <= 3'b000;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        error_q <= 1'b0;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            adr_q       <= base_adr;
                            remaining_q <= length;
                            busy_q      <= 1'b1;
                            state_q     <= ST_WAIT_SPACE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (space_ok) begin
                        cyc_q      <= 1'b1;
                        beat_cnt_q <= beats;
                        cti_q      <= (beats == BCW'(1)) ? 3'b111 : 3'b010;
                        state_q    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (wishbone_err) begin
                        cyc_q   <= 1'b0;
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (wishbone_ack) begin
                        adr_q       <= adr_q + 30'd1;
                        remaining_q <= remaining_q - 24'd1;
                        beat_cnt_q  <= beat_cnt_q - BCW'(1);
                        // Look one beat ahead so cti marks the beat now due.
                        cti_q       <= (beat_cnt_q == BCW'(2)) ? 3'b111 : 3'b010;
                        if (beat_cnt_q == BCW'(1)) begin
                            cyc_q   <= 1'b0;
                            state_q <= (remaining_q == 24'd1) ? ST_DRAIN : ST_WAIT_SPACE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign wishbone_adr   = adr_q;
    assign wishbone_dat_w = 32'h0;
    assign wishbone_sel   = 4'hF;
    assign wishbone_cyc   = cyc_q;
    assign wishbone_stb   = cyc_q;
    assign wishbone_we    = 1'b0;
    assign wishbone_cti   = cti_q;
    assign wishbone_bte   = 2'b00;
    assign source_valid   = !fifo_empty;
    assign source_data    = mem_q[rd_ptr_q[AW-1:0]][31:0];
    assign source_last    = !fifo_empty && mem_q[rd_ptr_q[AW-1:0]][32];

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_burst_reader
// Purpose  : Self-checking bench for wb_burst_reader: a wishbone slave with a
//            memory model, a randomised stream consumer and a scoreboard of
//            expected words, driven from a table of transfers plus hand
//            sequences for backpressure, error, reset and ignored starts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_burst_reader;

    localparam int BL = 16;
    localparam int FD = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [29:0] base_adr;
    logic [23:0] length;
    logic        busy, done, error;
    logic [29:0] wishbone_adr;
    logic [31:0] wishbone_dat_r;
    logic [31:0] wishbone_dat_w;
    logic [3:0]  wishbone_sel;
    logic        wishbone_cyc, wishbone_stb, wishbone_we;
    logic [2:0]  wishbone_cti;
    logic [1:0]  wishbone_bte;
    logic        wishbone_ack, wishbone_err;
    logic        source_valid, source_ready, source_last;
    logic [31:0] source_data;

    always #5 clock = ~clock;

    wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .start(start), .base_adr(base_adr),
        .length(length), .busy(busy), .done(done), .error(error),
        .wishbone_adr(wishbone_adr), .wishbone_dat_r(wishbone_dat_r),
        .wishbone_dat_w(wishbone_dat_w), .wishbone_sel(wishbone_sel),
        .wishbone_cyc(wishbone_cyc), .wishbone_stb(wishbone_stb),
        .wishbone_we(wishbone_we), .wishbone_cti(wishbone_cti),
        .wishbone_bte(wishbone_bte), .wishbone_ack(wishbone_ack),
        .wishbone_err(wishbone_err), .source_valid(source_valid),
        .source_ready(source_ready), .source_data(source_data),
        .source_last(source_last)
    );

    typedef struct {
        logic [29:0] base;
        int          len;
        int          ack_pct;
        int          rdy_pct;
        int          bursts;
    } vec_t;

    vec_t        vt [6];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [32:0] sbq [$];       // {last, data} expected on the source port
    int          ack_pct, rdy_pct, err_beat;
    int          beat_no, beat_left, rem_m, bursts, done_cnt;
    logic [29:0] exp_adr;
    bit          mon_en, err_fired, hold_pend, prev_stb;
    logic [31:0] held_data;
    logic        held_last;

    function automatic logic [31:0] memfn(input logic [29:0] a);
        return {a, 2'b01} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: at the falling edge observe the DUT, score it, then drive
    // the slave and consumer responses that the next rising edge samples.
    task automatic tick();
        bit          r, a, e;
        logic [32:0] w;
        @(negedge clock);
        // consumer side
        if (mon_en && hold_pend) begin
            check("src_hold_valid", 64'(source_valid), 64'(1'b1));
            check("src_hold_data", 64'(source_data), 64'(held_data));
            check("src_hold_last", 64'(source_last), 64'(held_last));
        end
        r = (int'($urandom_range(99)) < rdy_pct);
        source_ready = r;
        hold_pend = source_valid && !r;
        held_data = source_data;
        held_last = source_last;
        if (source_valid && r) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL src_extra: got word 0x%0h, want none", source_data);
            end else begin
                w = sbq.pop_front();
                check("src_data", 64'(source_data), 64'(w[31:0]));
                check("src_last", 64'(source_last), 64'(w[32]));
            end
        end
        if (done) done_cnt++;
        // bus side
        if (mon_en && prev_stb && !wishbone_stb)
            check("stb_drop_beats_left", 64'(beat_left), 64'(0));
        prev_stb = wishbone_stb;
        a = wishbone_stb && (int'($urandom_range(99)) < ack_pct);
        e = 1'b0;
        if (a && err_beat != 0 && beat_no + 1 == err_beat) begin
            a = 1'b0;
            e = 1'b1;
            err_fired = 1'b1;
        end
        wishbone_ack   = a;
        wishbone_err   = e;
        wishbone_dat_r = a ? memfn(wishbone_adr) : 32'hDEAD_BEEF;
        if (a) begin
            beat_no++;
            if (rem_m <= 0) begin
                if (mon_en) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL extra_beat: got beat at adr 0x%0h, want none", wishbone_adr);
                end
            end else begin
                if (beat_left == 0) begin
                    beat_left = (rem_m < BL) ? rem_m : BL;
                    bursts++;
                end
                if (mon_en) begin
                    check("bus_adr", 64'(wishbone_adr), 64'(exp_adr));
                    check("bus_cti", 64'(wishbone_cti), 64'((beat_left == 1) ? 3'b111 : 3'b010));
                end
                exp_adr = exp_adr + 30'd1;
                rem_m--;
                beat_left--;
            end
        end
    endtask

    task automatic do_start(input logic [29:0] b, input int n);
        logic [29:0] a;
        exp_adr = b; rem_m = n; beat_left = 0; bursts = 0; done_cnt = 0;
        beat_no = 0; err_fired = 1'b0; hold_pend = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = b + 30'(i);
            sbq.push_back({(i == n - 1), memfn(a)});
        end
        base_adr = b;
        length   = 24'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("busy_after_start", 64'(busy), 64'(n != 0));
        if (n == 0) check("done_len0", 64'(done), 64'(1'b1));
        tick();
        if (n != 0) check("stb_latency", 64'(wishbone_stb), 64'(1'b1));
    endtask

    task automatic wait_done(input int limit);
        int t;
        t = 0;
        while (done_cnt == 0 && t < limit) begin
            tick();
            t++;
        end
        if (done_cnt == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: got no done in %0d cycles, want done", limit);
        end
    endtask

    task automatic finish_vec(input int exp_bursts);
        repeat (3) tick();
        check("sb_empty", 64'(sbq.size()), 64'(0));
        check("burst_count", 64'(bursts), 64'(exp_bursts));
        check("done_once", 64'(done_cnt), 64'(1));
        check("busy_end", 64'(busy), 64'(1'b0));
        check("error_end", 64'(error), 64'(1'b0));
        check("cyc_end", 64'(wishbone_cyc), 64'(1'b0));
    endtask

    initial begin
        vt[0] = '{30'h100,       16, 100, 100, 1};
        vt[1] = '{30'h200,       40, 100, 100, 3};
        vt[2] = '{30'h3FFFFFF8,  20, 100, 100, 2};
        vt[3] = '{30'h1000,     100,  60,  50, 7};
        vt[4] = '{30'h50,         1, 100, 100, 1};
        vt[5] = '{30'h777,       17,  70,  30, 2};

        reset = 1'b1; start = 1'b0; base_adr = '0; length = '0;
        source_ready = 1'b0; wishbone_ack = 1'b0; wishbone_err = 1'b0;
        wishbone_dat_r = '0; ack_pct = 100; rdy_pct = 100; err_beat = 0;
        mon_en = 1'b0; prev_stb = 1'b0; hold_pend = 1'b0; err_fired = 1'b0;
        beat_no = 0; beat_left = 0; rem_m = 0; bursts = 0; done_cnt = 0;
        exp_adr = '0; held_data = '0; held_last = 1'b0;

        repeat (3) tick();
        check("rst_cyc", 64'(wishbone_cyc), 64'(1'b0));
        check("rst_stb", 64'(wishbone_stb), 64'(1'b0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_error", 64'(error), 64'(1'b0));
        check("rst_valid", 64'(source_valid), 64'(1'b0));
        check("rst_last", 64'(source_last), 64'(1'b0));
        check("rst_adr", 64'(wishbone_adr), 64'(0));
        check("rst_cti", 64'(wishbone_cti), 64'(0));
        reset = 1'b0;
        mon_en = 1'b1;
        tick();
        check("ties", 64'({wishbone_dat_w, wishbone_sel, wishbone_we, wishbone_bte}),
              64'({32'h0, 4'hF, 1'b0, 2'b00}));

        // table-driven transfers
        for (int i = 0; i < 6; i++) begin
            ack_pct = vt[i].ack_pct;
            rdy_pct = vt[i].rdy_pct;
            do_start(vt[i].base, vt[i].len);
            wait_done(5000);
            finish_vec(vt[i].bursts);
        end

        // consumer stalled: only two bursts fit, then the rest follow
        ack_pct = 100; rdy_pct = 0;
        do_start(30'h4000, 64);
        repeat (300) tick();
        check("bp_bursts", 64'(bursts), 64'(2));
        check("bp_cyc_low", 64'(wishbone_cyc), 64'(1'b0));
        check("bp_valid", 64'(source_valid), 64'(1'b1));
        check("bp_busy", 64'(busy), 64'(1'b1));
        rdy_pct = 100;
        wait_done(5000);
        finish_vec(4);

        // start while busy is ignored
        ack_pct = 80; rdy_pct = 80;
        do_start(30'h2000, 40);
        repeat (5) tick();
        base_adr = 30'h9999; length = 24'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_ignore", 64'(busy), 64'(1'b1));
        wait_done(5000);
        finish_vec(3);

        // zero length
        ack_pct = 100; rdy_pct = 100;
        do_start(30'hABC, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("len0_no_cyc", 64'(wishbone_cyc), 64'(1'b0));
        end
        finish_vec(0);

        // bus error on beat 5 of the first burst
        mon_en = 1'b0; ack_pct = 100; rdy_pct = 0; err_beat = 5;
        do_start(30'h600, 40);
        for (int t = 0; t < 200 && !err_fired; t++) tick();
        if (!err_fired) begin
            n_vec++;
            n_miss++;
            $display("FAIL err_timeout: got no beat 5, want err beat");
        end
        tick();
        check("err_cyc", 64'(wishbone_cyc), 64'(1'b0));
        check("err_stb", 64'(wishbone_stb), 64'(1'b0));
        check("err_error", 64'(error), 64'(1'b1));
        check("err_done", 64'(done), 64'(1'b1));
        check("err_flush", 64'(source_valid), 64'(1'b0));
        check("err_busy", 64'(busy), 64'(1'b0));
        tick();
        check("err_sticky", 64'(error), 64'(1'b1));
        err_beat = 0;
        sbq.delete();
        mon_en = 1'b1; rdy_pct = 100;
        do_start(30'h700, 4);
        check("err_cleared", 64'(error), 64'(1'b0));
        wait_done(5000);
        finish_vec(1);

        // reset in the middle of a burst
        ack_pct = 100; rdy_pct = 0;
        do_start(30'h800, 40);
        repeat (4) tick();
        check("pre_rst_stb", 64'(wishbone_stb), 64'(1'b1));
        mon_en = 1'b0;
        reset = 1'b1;
        tick();
        check("mrst_cyc", 64'(wishbone_cyc), 64'(1'b0));
        check("mrst_stb", 64'(wishbone_stb), 64'(1'b0));
        check("mrst_busy", 64'(busy), 64'(1'b0));
        check("mrst_done", 64'(done), 64'(1'b0));
        check("mrst_error", 64'(error), 64'(1'b0));
        check("mrst_valid", 64'(source_valid), 64'(1'b0));
        check("mrst_last", 64'(source_last), 64'(1'b0));
        check("mrst_adr", 64'(wishbone_adr), 64'(0));
        check("mrst_cti", 64'(wishbone_cti), 64'(0));
        reset = 1'b0;
        sbq.delete();
        tick();
        mon_en = 1'b1; rdy_pct = 100;
        do_start(30'h900, 3);
        wait_done(5000);
        finish_vec(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
